// File: rtl/design02_op_sequencer_if.sv
// design02_op_sequencer_if: operand enqueue, downstream start/result/check and consumer signals.
// The master modport is the sequencer side and the slave modport is its environment.
interface design02_op_sequencer_if #(
    parameter int W     = 6,
    parameter int CNT_W = 16
);
    logic [W-1:0]     enq_a, enq_b, enq_c;
    logic             EN_enq, RDY_enq;
    logic [W-1:0]     start_a, start_b;
    logic             EN_start, STready;
    logic [W-1:0]     result_c, result;
    logic             RESready;
    logic [W-1:0]     check_d, check;
    logic             EN_check, CHready;
    logic [W-1:0]     out_data;
    logic             out_valid, EN_out;
    logic [CNT_W-1:0] issued_cnt;
    logic [7:0]       mismatch_cnt;
    modport master (
        input  enq_a, enq_b, enq_c, EN_enq, STready, result, RESready, check, CHready, EN_out,
        output RDY_enq, start_a, start_b, EN_start, result_c, check_d, EN_check,
               out_data, out_valid, issued_cnt, mismatch_cnt
    );
    modport slave (
        output enq_a, enq_b, enq_c, EN_enq, STready, result, RESready, check, CHready, EN_out,
        input  RDY_enq, start_a, start_b, EN_start, result_c, check_d, EN_check,
               out_data, out_valid, issued_cnt, mismatch_cnt
    );
endinterface

// File: rtl/design02_op_sequencer.sv
// design02_op_sequencer: FIFO-buffered start -> result -> check sequencer with a one-entry output register.
// Optional result scoreboard enabled by DESIGN02_SCOREBOARD_EN.
module design02_op_sequencer #(
    parameter int W     = 6,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input logic CLK,
    input logic RST,
    design02_op_sequencer_if.master io
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, START, WAIT_RES, CHECK} state_t;
    state_t         state, state_n;
    logic [1:0]     rst_sync;
    logic           rst_i;
    logic [W-1:0]   mem_a [DEPTH];
    logic [W-1:0]   mem_b [DEPTH];
    logic [W-1:0]   mem_c [DEPTH];
    logic [AW:0]    wr_ptr, rd_ptr;
    logic [AW-1:0]  rd_idx;
    logic [W-1:0]   cur_c, res_reg;
    logic           push, pop, empty, full, en_check, res_take;

    // Assertion is immediate; release is retimed to the clock.
    always_ff @(posedge CLK or posedge RST)
        if (RST) rst_sync <= 2'b11;
        else rst_sync <= {rst_sync[0], 1'b0};
    assign rst_i = rst_sync[1];

    assign rd_idx   = rd_ptr[AW-1:0];
    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign push     = io.EN_enq && !full;
    assign pop      = state == START && io.STready;
    assign res_take = state == WAIT_RES && io.RESready;
    assign io.RDY_enq = !full;

    always_ff @(posedge CLK)
        if (push) begin
            mem_a[wr_ptr[AW-1:0]] <= io.enq_a;
            mem_b[wr_ptr[AW-1:0]] <= io.enq_b;
            mem_c[wr_ptr[AW-1:0]] <= io.enq_c;
        end

    always_ff @(posedge CLK or posedge rst_i)
        if (rst_i) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cur_c         <= '0;
            res_reg       <= '0;
            io.out_data   <= '0;
            io.out_valid  <= 1'b0;
            io.issued_cnt <= '0;
        end else begin
            state <= state_n;
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) begin
                rd_ptr        <= rd_ptr + (AW+1)'(1);
                cur_c         <= mem_c[rd_idx];
                io.issued_cnt <= io.issued_cnt + CNT_W'(1);
            end
            if (res_take) res_reg <= io.result;
            if (en_check) begin
                io.out_data  <= io.check;
                io.out_valid <= 1'b1;
            end else if (io.EN_out) io.out_valid <= 1'b0;
        end

    // Capture waits until the consumer has room, so a held result is never overwritten.
    always_comb begin
        en_check    = state == CHECK && io.CHready && (!io.out_valid || io.EN_out);
        state_n     = state == IDLE     ? (empty       ? IDLE  : START)
                    : state == START    ? (io.STready  ? WAIT_RES : START)
                    : state == WAIT_RES ? (io.RESready ? CHECK : WAIT_RES)
                    :                     (en_check    ? IDLE  : CHECK);
        io.start_a  = state == START ? mem_a[rd_idx] : '0;
        io.start_b  = state == START ? mem_b[rd_idx] : '0;
        io.EN_start = pop;
        io.result_c = state == WAIT_RES ? cur_c : '0;
        io.check_d  = state == CHECK ? res_reg : '0;
        io.EN_check = en_check;
    end

`ifdef DESIGN02_SCOREBOARD_EN
    logic [W-1:0] cur_exp;
    logic [7:0]   mis;
    always_ff @(posedge CLK or posedge rst_i)
        if (rst_i) begin
            cur_exp <= '0;
            mis     <= '0;
        end else begin
            if (pop) cur_exp <= mem_a[rd_idx] + mem_b[rd_idx];
            if (res_take && io.result != cur_exp && mis != 8'hFF) mis <= mis + 8'd1;
        end
    assign io.mismatch_cnt = mis;
`else
    assign io.mismatch_cnt = '0;
`endif
endmodule

// File: tb/tb_design02_op_sequencer.sv
// tb_design02_op_sequencer: directed and randomized checks against a queue-based reference model.
module tb_design02_op_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic mix;
    logic [5:0] res_err, la, lb;
    logic [5:0] st_q[$], exp_q[$], out_q[$];
    int   enq_since, nz_cnt;

    always #5 clk = ~clk;

    design02_op_sequencer_if #(.W(6), .CNT_W(16)) io();
    design02_op_sequencer #(.W(6), .DEPTH(4), .CNT_W(16)) dut (.CLK(clk), .RST(rst), .io(io));

    // Downstream model: result is a+b (plus c and an injected error when mixing), check echoes or scrambles it.
    always_comb begin
        io.result = mix ? 6'(la + lb + io.result_c + res_err) : 6'(la + lb + res_err);
        io.check  = mix ? (io.check_d ^ 6'h2A) : io.check_d;
    end

    always @(posedge clk or posedge rst)
        if (rst) begin
            la = '0;
            lb = '0;
            enq_since = 0;
            nz_cnt = 0;
        end else begin
            if (io.EN_enq && io.RDY_enq) begin
                exp_q.push_back(6'((io.enq_a + io.enq_b + (mix ? io.enq_c : 6'd0)) ^ (mix ? 6'h2A : 6'h0)));
                enq_since++;
                if (mix && io.enq_c != 0) nz_cnt++;
            end
            if (io.EN_start) begin
                la = io.start_a;
                lb = io.start_b;
                st_q.push_back(io.start_a);
            end
            if (io.out_valid && io.EN_out) out_q.push_back(io.out_data);
        end

    task automatic clear_q();
        st_q.delete();
        exp_q.delete();
        out_q.delete();
    endtask

    task automatic put(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        @(negedge clk);
        io.EN_enq = 1'b1;
        io.enq_a = a;
        io.enq_b = b;
        io.enq_c = c;
    endtask

    task automatic drain(input int budget);
        int i;
        io.EN_enq = 1'b0;
        io.STready = 1'b1;
        io.RESready = 1'b1;
        io.CHready = 1'b1;
        io.EN_out = 1'b1;
        for (i = 0; i < budget && !(out_q.size() >= exp_q.size() && !io.out_valid); i++) @(negedge clk);
        total_cnt++;
        if (i >= budget) $display("FAIL drain_timeout got %0d outputs exp %0d", out_q.size(), exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        io.EN_enq = 0; io.enq_a = 0; io.enq_b = 0; io.enq_c = 0;
        io.STready = 0; io.RESready = 0; io.CHready = 0; io.EN_out = 0;
        mix = 0; res_err = 0;
        repeat (3) @(negedge clk);
        #1;
        total_cnt++; if (io.RDY_enq !== 1'b1) $display("FAIL reset_rdy got %0d exp 1", io.RDY_enq); else pass_cnt++;
        total_cnt++; if (io.out_valid !== 1'b0 || io.out_data !== 6'd0) $display("FAIL reset_out got v=%0d d=%0d exp 0 0", io.out_valid, io.out_data); else pass_cnt++;
        total_cnt++; if (io.issued_cnt !== 16'd0 || io.mismatch_cnt !== 8'd0) $display("FAIL reset_cnt got %0d %0d exp 0 0", io.issued_cnt, io.mismatch_cnt); else pass_cnt++;
        total_cnt++; if ({io.EN_start, io.EN_check, io.start_a, io.result_c, io.check_d} !== '0) $display("FAIL reset_outputs got nonzero exp 0"); else pass_cnt++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single();
        clear_q();
        io.STready = 1; io.RESready = 1; io.CHready = 1; io.EN_out = 0;
        put(6'd3, 6'd5, 6'd1);
        @(negedge clk); io.EN_enq = 0; #1;
        total_cnt++; if (io.EN_start !== 1'b0) $display("FAIL single_c1_en_start got %0d exp 0", io.EN_start); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (io.EN_start !== 1'b1 || io.start_a !== 6'd3 || io.start_b !== 6'd5) $display("FAIL single_c2_start got en=%0d a=%0d b=%0d exp 1 3 5", io.EN_start, io.start_a, io.start_b); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (io.result_c !== 6'd1) $display("FAIL single_c3_result_c got %0d exp 1", io.result_c); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (io.out_valid !== 1'b0 || io.EN_check !== 1'b1 || io.check_d !== 6'd8) $display("FAIL single_c4 got v=%0d en=%0d d=%0d exp 0 1 8", io.out_valid, io.EN_check, io.check_d); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (io.out_valid !== 1'b1 || io.out_data !== 6'd8) $display("FAIL single_out got v=%0d d=%0d exp 1 8", io.out_valid, io.out_data); else pass_cnt++;
        total_cnt++; if (io.issued_cnt !== 16'd1 || io.mismatch_cnt !== 8'd0) $display("FAIL single_cnt got %0d %0d exp 1 0", io.issued_cnt, io.mismatch_cnt); else pass_cnt++;
        io.EN_out = 1;
        @(negedge clk); io.EN_out = 0; #1;
        total_cnt++; if (io.out_valid !== 1'b0) $display("FAIL single_take got %0d exp 0", io.out_valid); else pass_cnt++;
    endtask

    task automatic test_fifo_full();
        clear_q();
        io.STready = 0; io.EN_out = 1;
        for (int i = 1; i <= 4; i++) put(6'(i), 6'd0, 6'd0);
        @(negedge clk); io.EN_enq = 0; #1;
        total_cnt++; if (io.RDY_enq !== 1'b0) $display("FAIL full_rdy got %0d exp 0", io.RDY_enq); else pass_cnt++;
        io.EN_enq = 1; io.enq_a = 6'd9;
        @(negedge clk); io.EN_enq = 0;
        drain(100);
        total_cnt++; if (st_q.size() != 4) $display("FAIL full_issue_count got %0d exp 4", st_q.size()); else pass_cnt++;
        for (int i = 0; i < st_q.size() && i < 4; i++) begin
            total_cnt++; if (st_q[i] !== 6'(i + 1)) $display("FAIL full_order[%0d] got %0d exp %0d", i, st_q[i], i + 1); else pass_cnt++;
        end
        total_cnt++; if (io.issued_cnt !== 16'(enq_since) || enq_since != 5) $display("FAIL full_issued got %0d exp %0d", io.issued_cnt, 5); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        clear_q();
        io.STready = 1; io.RESready = 0; io.CHready = 0; io.EN_out = 0;
        put(6'd10, 6'd20, 6'd7);
        @(negedge clk); io.EN_enq = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            total_cnt++; if (io.result_c !== 6'd7 || io.EN_check !== 1'b0) $display("FAIL bp_wait_res[%0d] got rc=%0d en=%0d exp 7 0", i, io.result_c, io.EN_check); else pass_cnt++;
        end
        @(negedge clk); io.RESready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); io.RESready = 0; #1;
            total_cnt++; if (io.EN_check !== 1'b0 || io.out_valid !== 1'b0 || io.check_d !== 6'd30) $display("FAIL bp_check_stall[%0d] got en=%0d v=%0d d=%0d exp 0 0 30", i, io.EN_check, io.out_valid, io.check_d); else pass_cnt++;
        end
        @(negedge clk); io.CHready = 1; #1;
        total_cnt++; if (io.EN_check !== 1'b1) $display("FAIL bp_release got %0d exp 1", io.EN_check); else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++; if (io.out_valid !== 1'b1 || io.out_data !== 6'd30 || io.EN_check !== 1'b0) $display("FAIL bp_capture got v=%0d d=%0d en=%0d exp 1 30 0", io.out_valid, io.out_data, io.EN_check); else pass_cnt++;
        drain(50);
        total_cnt++; if (out_q.size() != 1) $display("FAIL bp_once got %0d exp 1", out_q.size()); else pass_cnt++;
    endtask

    task automatic test_output_stall();
        clear_q();
        io.STready = 1; io.RESready = 1; io.CHready = 1; io.EN_out = 0;
        put(6'd1, 6'd1, 6'd0);
        put(6'd2, 6'd3, 6'd0);
        @(negedge clk); io.EN_enq = 0;
        repeat (12) @(negedge clk);
        #1;
        total_cnt++; if (io.out_valid !== 1'b1 || io.out_data !== 6'd2) $display("FAIL stall_hold got v=%0d d=%0d exp 1 2", io.out_valid, io.out_data); else pass_cnt++;
        total_cnt++; if (io.EN_check !== 1'b0 || io.check_d !== 6'd5) $display("FAIL stall_check got en=%0d d=%0d exp 0 5", io.EN_check, io.check_d); else pass_cnt++;
        io.EN_out = 1; #1;
        total_cnt++; if (io.EN_check !== 1'b1) $display("FAIL stall_same_cycle got %0d exp 1", io.EN_check); else pass_cnt++;
        @(negedge clk); io.EN_out = 0; #1;
        total_cnt++; if (io.out_valid !== 1'b1 || io.out_data !== 6'd5) $display("FAIL stall_swap got v=%0d d=%0d exp 1 5", io.out_valid, io.out_data); else pass_cnt++;
        drain(50);
    endtask

    task automatic test_scoreboard();
        int m0, em;
        clear_q();
        mix = 0;
        m0 = io.mismatch_cnt;
        res_err = 6'd4;
        put(6'd63, 6'd2, 6'd0);
        @(negedge clk); io.EN_enq = 0;
        drain(50);
`ifdef DESIGN02_SCOREBOARD_EN
        em = m0 + 1;
`else
        em = 0;
`endif
        total_cnt++; if (io.mismatch_cnt !== 8'(em)) $display("FAIL sb_mismatch got %0d exp %0d", io.mismatch_cnt, em); else pass_cnt++;
        res_err = 6'd0;
        put(6'd63, 6'd1, 6'd0);
        @(negedge clk); io.EN_enq = 0;
        drain(50);
        total_cnt++; if (io.mismatch_cnt !== 8'(em)) $display("FAIL sb_match got %0d exp %0d", io.mismatch_cnt, em); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        clear_q();
        io.STready = 1; io.RESready = 0; io.CHready = 1; io.EN_out = 1;
        put(6'd4, 6'd4, 6'd5);
        put(6'd6, 6'd6, 6'd6);
        put(6'd7, 6'd7, 6'd7);
        @(negedge clk); io.EN_enq = 0; #1;
        total_cnt++; if (io.result_c !== 6'd5) $display("FAIL rm_pre got %0d exp 5", io.result_c); else pass_cnt++;
        #2 rst = 1'b1; #1;
        total_cnt++; if ({io.EN_start, io.EN_check, io.out_valid} !== 3'b000 || io.RDY_enq !== 1'b1 || io.issued_cnt !== 16'd0) $display("FAIL rm_async got st=%0d ck=%0d v=%0d rdy=%0d cnt=%0d exp 0 0 0 1 0", io.EN_start, io.EN_check, io.out_valid, io.RDY_enq, io.issued_cnt); else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        clear_q();
        io.RESready = 1;
        repeat (15) @(negedge clk);
        total_cnt++; if (st_q.size() != 0 || io.out_valid !== 1'b0) $display("FAIL rm_stale got issued=%0d v=%0d exp 0 0", st_q.size(), io.out_valid); else pass_cnt++;
    endtask

    task automatic test_random();
        int m0, em, n;
        clear_q();
        mix = 1; res_err = 0;
        m0 = io.mismatch_cnt;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            io.EN_enq = 1'($urandom_range(0, 1));
            io.enq_a = 6'($urandom);
            io.enq_b = 6'($urandom);
            io.enq_c = 6'($urandom);
            io.STready = $urandom_range(0, 3) != 0;
            io.RESready = $urandom_range(0, 3) != 0;
            io.CHready = $urandom_range(0, 3) != 0;
            io.EN_out = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        drain(200);
        n = exp_q.size();
        total_cnt++; if (out_q.size() != n) $display("FAIL rand_count got %0d exp %0d", out_q.size(), n); else pass_cnt++;
        for (int i = 0; i < n && i < out_q.size(); i++) begin
            total_cnt++; if (out_q[i] !== exp_q[i]) $display("FAIL rand_data[%0d] got %0d exp %0d", i, out_q[i], exp_q[i]); else pass_cnt++;
        end
        total_cnt++; if (io.issued_cnt !== 16'(enq_since)) $display("FAIL rand_issued got %0d exp %0d", io.issued_cnt, enq_since); else pass_cnt++;
`ifdef DESIGN02_SCOREBOARD_EN
        em = m0 + nz_cnt > 255 ? 255 : m0 + nz_cnt;
`else
        em = 0;
`endif
        total_cnt++; if (io.mismatch_cnt !== 8'(em)) $display("FAIL rand_mismatch got %0d exp %0d", io.mismatch_cnt, em); else pass_cnt++;
        mix = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fifo_full();
        test_backpressure();
        test_output_stall();
        test_scoreboard();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/design02_op_sequencer.md
Name: design02_op_sequencer

Overview:
Upstream driver stage for the mkDesign_02 start/result/check datapath. Buffers operand triples (a, b, c) in a small FIFO and issues each one to the downstream start port. It then reads result(c), feeds that result back through check(d), and holds the returned check value in a one-entry output register for the consumer. Transactions are strictly in order with one in flight at a time.

Parameters:
W, 6, operand/result width in bits; must match the downstream block
DEPTH, 4, operand FIFO entries; power of two, at least 2
CNT_W, 16, width of the issued-transaction counter

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  asynchronous, active-high reset
enq_a  in  W  operand a
enq_b  in  W  operand b
enq_c  in  W  result-select argument c
EN_enq  in  1  enqueue strobe; honoured only when RDY_enq=1
RDY_enq  out  1  FIFO not full
start_a  out  W  to downstream start_a
start_b  out  W  to downstream start_b
EN_start  out  1  to downstream EN_start
STready  in  1  downstream start ready
result_c  out  W  to downstream result_c
result  in  W  downstream result value
RESready  in  1  downstream result ready
check_d  out  W  to downstream check_d
EN_check  out  1  to downstream EN_check
check  in  W  downstream check return value
CHready  in  1  downstream check ready
out_data  out  W  captured check return value
out_valid  out  1  out_data is valid
EN_out  in  1  consumer takes out_data; ignored when out_valid=0
issued_cnt  out  CNT_W  completed start handshakes, wraps modulo 2^CNT_W
mismatch_cnt  out  8  scoreboard mismatches; see Optional Feature

Behaviour:
- Reset (async assert, sync deassert inside the block): FIFO empty, FSM=IDLE, out_valid=0, out_data=0, issued_cnt=0, mismatch_cnt=0, all EN_* outputs 0, data outputs 0. Reset asserted mid-transaction aborts it with no partial output.
- FIFO: RDY_enq = (count != DEPTH).
  - Enqueue when EN_enq && RDY_enq.
  - Pop only on the START handshake.
  - Simultaneous push and pop while full is not possible, because RDY_enq=0 when full.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pointers are log2(DEPTH) bits wide, with an extra wrap bit for full/empty.
- FSM states:
  - IDLE: if FIFO non-empty, go to START on the next cycle.
  - START: start_a/start_b = FIFO head a/b; EN_start = STready.
    - If STready=1: pop the FIFO, latch head c and expected (a+b) mod 2^W into cur_c/cur_exp, increment issued_cnt, go to WAIT_RES.
    - If STready=0: hold.
  - WAIT_RES: result_c = cur_c.
    - If RESready=1: capture result into res_reg, go to CHECK.
  - CHECK: check_d = res_reg; EN_check = CHready && (!out_valid || EN_out).
    - On EN_check: out_data <= check, out_valid <= 1, go to IDLE.
    - Otherwise stall in CHECK, so the output register is never overwritten while full.
- Output register:
  - EN_out && out_valid clears out_valid next cycle, unless a new capture occurs in the same cycle.
  - If a new capture occurs in the same cycle, out_valid stays 1 with the new data.
- Outputs are registered state or a combinational function of state and the *ready inputs only. There is no combinational path from result/check into EN_*.
- Minimum latency from enqueue to out_valid, with all readies high: 4 cycles.
  - Cycle 0: enqueue.
  - Cycle 1: FSM in IDLE, sees non-empty.
  - Cycle 2: START handshake.
  - Cycle 3: WAIT_RES captures result.
  - Cycle 4: CHECK captures; out_valid is high after the cycle-4 edge.
- issued_cnt wraps from 2^CNT_W-1 to 0.

Optional Feature:
DESIGN02_SCOREBOARD_EN
- Defined: on the WAIT_RES capture, compare result against cur_exp. On mismatch, increment mismatch_cnt, saturating at 255.
- Not defined: no comparator or cur_exp storage; mismatch_cnt is tied to 0.

Test Plan:
- Single transaction: reset, then enq a=3, b=5, c=1, all readies=1, downstream returns result=8, check=8.
  - Required: EN_start in cycle 2, out_valid=1 after 4 cycles with out_data=8, issued_cnt=1.
  - With the macro: mismatch_cnt=0.
- FIFO full: STready=0, enq 4 triples.
  - Required: RDY_enq=0 after the 4th; a 5th EN_enq is ignored.
  - Required: releasing STready issues the 4 triples in order (a=1,2,3,4 on start_a).
- Backpressure: hold RESready=0 for 5 cycles, then CHready=0 for 3 cycles.
  - Required: FSM holds, result_c=cur_c stable, EN_check stays 0 until CHready=1, then out_data is captured once.
- Output stall: out_valid=1 with EN_out=0, and a second transaction reaches CHECK.
  - Required: EN_check=0 and the FSM holds in CHECK.
  - Required: when EN_out=1 that cycle, the capture occurs in the same cycle and out_valid stays 1 with the new data.
- Scoreboard (macro defined): a=63, b=2 (expected 1), downstream result=5.
  - Required: mismatch_cnt=1.
  - Required: a=63, b=1 with result=0 leaves mismatch_cnt unchanged.
- Reset mid-operation: assert RST while in WAIT_RES with 2 entries queued.
  - Required: outputs are immediately EN_*=0, out_valid=0, RDY_enq=1, issued_cnt=0.
  - Required: after deassertion, no stale entry is issued.
